// File: rtl/xil_oddr_bus.sv
// ---------------------------------------------------------------------------
// xil_oddr_bus
//
// DDR output path for the HyperRAM DQ/RWDS pins. Rise/fall beat pairs are
// queued in a small FIFO (valid/ready handshake) and sent out one pair per
// clock. dout carries the rise half while clk is high and the fall half while
// clk is low. Each burst is framed by dout_oe: the enable comes up OE_LEAD
// cycles before the first data cycle and stays up OE_TRAIL cycles after the
// last one. If the FIFO runs dry mid-burst, the output idles with the enable
// held and underrun pulses. The burst then resumes with the next beat.
//
// Parameters:
//   WIDTH    lanes per beat (1..32)
//   DEPTH    FIFO entries, power of two, >= 2
//   OE_LEAD  enable lead-in cycles before the first data cycle (0..15)
//   OE_TRAIL enable tail cycles after the last data cycle (0..15)
//   IDLE_VAL value driven on both phases when no beat is being output
//
// Ports:
//   clk       single clock; state on rising edge, output mux on both phases
//   reset     asynchronous, active-high reset
//   in_valid  beat offered
//   in_ready  FIFO can accept a beat (low while full or in reset)
//   in_ris    beat data for the clk-high phase
//   in_fal    beat data for the clk-low phase
//   in_last   beat closes its burst
//   dout      DDR data to the pads
//   dout_oe   registered pad drive enable
//   busy      FSM not idle or FIFO holding beats
//   underrun  one-cycle pulse for each data cycle with nothing to send
//
// Build option:
//   XIL_ODDR_BUS_PRIM_EN  when defined, each lane is driven by an ODDRE1
//                         primitive fed from the q_ris/q_fal registers. This
//                         adds one cycle of output latency. dout_oe and
//                         underrun are delayed to match. When undefined, a
//                         behavioural dual-edge mux is used. The undefined
//                         build is used for lint and simulation.
// ---------------------------------------------------------------------------
module xil_oddr_bus #(
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       OE_LEAD  = 1,
  parameter int unsigned       OE_TRAIL = 1,
  parameter logic [WIDTH-1:0]  IDLE_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_ris,
  input  logic [WIDTH-1:0] in_fal,
  input  logic             in_last,
  output logic [WIDTH-1:0] dout,
  output logic             dout_oe,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LEAD_LAST  = (OE_LEAD  > 0) ? 4'(OE_LEAD  - 1) : 4'd0;
  localparam logic [3:0]  TRAIL_LAST = (OE_TRAIL > 0) ? 4'(OE_TRAIL - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEAD,
    S_DATA,
    S_TRAIL
  } state_t;

  state_t state;
  logic [3:0] cnt;

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem_ris  [DEPTH];
  logic [WIDTH-1:0] mem_fal  [DEPTH];
  logic             mem_last [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic empty;
  logic full;
  logic push;
  logic pop;

  logic [WIDTH-1:0] head_ris;
  logic [WIDTH-1:0] head_fal;
  logic             head_last;

  // Output pre-registers, one rise/fall pair per clock
  logic [WIDTH-1:0] q_ris;
  logic [WIDTH-1:0] q_fal;
  logic             oe_q;
  logic             underrun_q;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  // in_ready is held low during reset so nothing upstream counts a beat as
  // accepted while the FIFO is being flushed.
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  // Beats only leave the FIFO while a burst is in its data phase. Push and
  // pop may happen in the same cycle.
  assign pop      = (state == S_DATA) && !empty;

  assign head_ris  = mem_ris[rd_ptr];
  assign head_fal  = mem_fal[rd_ptr];
  assign head_last = mem_last[rd_ptr];

  assign busy = (state != S_IDLE) || !empty;

  // FIFO payload. This storage has no reset: occupancy is tracked by the
  // pointers and count, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ris[wr_ptr]  <= in_ris;
      mem_fal[wr_ptr]  <= in_fal;
      mem_last[wr_ptr] <= in_last;
    end
  end

  // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers
  // wrap naturally at their width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Burst framing FSM. oe_q mirrors "state was not IDLE" one cycle late. As
  // a result, the enable rises together with the first LEAD-counted cycle
  // (or with the first data cycle when OE_LEAD is 0). It falls right after
  // the last TRAIL cycle. Because IDLE always lasts at least one cycle,
  // back-to-back bursts always show a one-cycle enable gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      oe_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      oe_q       <= (state != S_IDLE);
      // An empty FIFO in DATA idles the output for this cycle. The pulse is
      // registered so it lines up with that idle output cycle.
      underrun_q <= (state == S_DATA) && empty;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            cnt   <= '0;
            state <= (OE_LEAD == 0) ? S_DATA : S_LEAD;
          end
        end
        S_LEAD: begin
          if (cnt == LEAD_LAST) begin
            cnt   <= '0;
            state <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (pop && head_last) begin
            cnt   <= '0;
            state <= (OE_TRAIL == 0) ? S_IDLE : S_TRAIL;
          end
        end
        S_TRAIL: begin
          if (cnt == TRAIL_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output pair register. It takes the popped beat, or the idle value when
  // nothing is popped (lead, trail, underrun and idle cycles). The async
  // reset forces the idle value onto the pins without waiting for an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_ris <= IDLE_VAL;
      q_fal <= IDLE_VAL;
    end else if (pop) begin
      q_ris <= head_ris;
      q_fal <= head_fal;
    end else begin
      q_ris <= IDLE_VAL;
      q_fal <= IDLE_VAL;
    end
  end

`ifdef XIL_ODDR_BUS_PRIM_EN
  // The ODDRE1 stage adds a cycle between q_ris/q_fal and the pins. The
  // enable and underrun flag are delayed by the same amount so the
  // alignment seen at the pads matches the behavioural build.
  logic oe_d;
  logic underrun_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe_d       <= 1'b0;
      underrun_d <= 1'b0;
    end else begin
      oe_d       <= oe_q;
      underrun_d <= underrun_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ODDRE1 #(
      .SRVAL(1'b0)
    ) u_oddr (
      .Q  (dout[i]),
      .C  (clk),
      .D1 (q_ris[i]),
      .D2 (q_fal[i]),
      .SR (1'b0)
    );
  end

  assign dout_oe  = oe_d;
  assign underrun = underrun_d;
`else
  // Behavioural dual-edge output: the rise half is shown while clk is high
  // and the fall half while clk is low. Both halves were loaded at the same
  // rising edge.
  assign dout     = clk ? q_ris : q_fal;
  assign dout_oe  = oe_q;
  assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_xil_oddr_bus.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_xil_oddr_bus
//
// Two instances are exercised. Instance 0 uses OE_LEAD=1 and OE_TRAIL=1.
// Instance 1 uses OE_LEAD=0 and OE_TRAIL=0. Both use DEPTH=4 and a non-zero
// idle value. Accepted beats go into a per-instance expectation queue. A
// monitor per instance samples both output phases each cycle, pops the
// queue on data cycles, and records the enable framing.
// ---------------------------------------------------------------------------
module tb_xil_oddr_bus;

  localparam int             W    = 8;
  localparam logic [W-1:0]   IDLE = 8'hE7;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic         in_valid_x [2];
  logic [W-1:0] in_ris_x   [2];
  logic [W-1:0] in_fal_x   [2];
  logic         in_last_x  [2];
  logic         in_ready_x [2];
  logic [W-1:0] dout_x     [2];
  logic         oe_x       [2];
  logic         busy_x     [2];
  logic         ur_x       [2];

  xil_oddr_bus #(
    .WIDTH(W), .DEPTH(4), .OE_LEAD(1), .OE_TRAIL(1), .IDLE_VAL(IDLE)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid_x[0]),
    .in_ready (in_ready_x[0]),
    .in_ris   (in_ris_x[0]),
    .in_fal   (in_fal_x[0]),
    .in_last  (in_last_x[0]),
    .dout     (dout_x[0]),
    .dout_oe  (oe_x[0]),
    .busy     (busy_x[0]),
    .underrun (ur_x[0])
  );

  xil_oddr_bus #(
    .WIDTH(W), .DEPTH(4), .OE_LEAD(0), .OE_TRAIL(0), .IDLE_VAL(IDLE)
  ) u_dut_nolead (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid_x[1]),
    .in_ready (in_ready_x[1]),
    .in_ris   (in_ris_x[1]),
    .in_fal   (in_fal_x[1]),
    .in_last  (in_last_x[1]),
    .dout     (dout_x[1]),
    .dout_oe  (oe_x[1]),
    .busy     (busy_x[1]),
    .underrun (ur_x[1])
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];

  logic mon_en      [2];
  int   oe_cycles   [2];
  int   ur_count    [2];
  int   lead_meas   [2];
  int   trail_meas  [2];
  int   last_gap    [2];
  int   stall_total [2];

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic void sbPush(input int k, input logic [15:0] v);
    if (k == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic int sbSize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [15:0] sbPop(input int k);
    if (k == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // Offer one beat starting at a falling edge. Wait (bounded) for in_ready
  // and record the beat as expected output once it is accepted.
  task automatic applyStimulus(input int k, input logic [W-1:0] r,
                               input logic [W-1:0] f, input logic l);
    logic rdy;
    int   stalls;
    stalls = 0;
    in_valid_x[k] = 1'b1;
    in_ris_x[k]   = r;
    in_fal_x[k]   = f;
    in_last_x[k]  = l;
    forever begin
      rdy = in_ready_x[k];
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
      stalls++;
      if (stalls > 64) begin
        checkOutput("push_timeout", stalls, 0);
        break;
      end
    end
    if (rdy) sbPush(k, {r, f});
    stall_total[k] += stalls;
    @(negedge clk);
    in_valid_x[k] = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitIdle(input int k);
    int n;
    n = 0;
    while ((busy_x[k] || oe_x[k]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("drain_timeout%0d", k), (n >= 200), 0);
    repeat (2) @(negedge clk);
  endtask

  // Per-cycle observer: rise half sampled while clk is high, fall half
  // sampled while clk is low.
  task automatic monitorOutput(input int k);
    logic [W-1:0] s_ris;
    logic [W-1:0] s_fal;
    logic         s_oe;
    logic         s_ur;
    logic         en0;
    logic         prev_oe = 1'b0;
    logic         pend    = 1'b0;
    int           cyc       = 0;
    int           rise_cyc  = 0;
    int           last_data = 0;
    int           gap       = 0;
    logic [15:0]  exp_v;
    forever begin
      @(posedge clk);
      #2;
      en0   = mon_en[k];
      s_ris = dout_x[k];
      s_oe  = oe_x[k];
      s_ur  = ur_x[k];
      @(negedge clk);
      #2;
      s_fal = dout_x[k];
      cyc++;
      if (!en0 || !mon_en[k]) begin
        prev_oe = 1'b0;
        pend    = 1'b0;
        gap     = 0;
        continue;
      end
      if (s_oe) begin
        oe_cycles[k]++;
        if (!prev_oe) begin
          rise_cyc    = cyc;
          pend        = 1'b1;
          last_gap[k] = gap;
        end
        if (s_ur) begin
          ur_count[k]++;
          checkOutput($sformatf("underrun_dout%0d", k), {s_ris, s_fal}, {IDLE, IDLE});
        end else if ({s_ris, s_fal} != {IDLE, IDLE}) begin
          if (sbSize(k) == 0) begin
            checkOutput($sformatf("spurious_beat%0d", k), {s_ris, s_fal}, {IDLE, IDLE});
          end else begin
            exp_v = sbPop(k);
            checkOutput($sformatf("beat%0d", k), {s_ris, s_fal}, exp_v);
            if (pend) begin
              lead_meas[k] = cyc - rise_cyc;
              pend         = 1'b0;
            end
            last_data = cyc;
          end
        end
      end else begin
        if (prev_oe) begin
          trail_meas[k] = cyc - last_data - 1;
          gap           = 0;
        end
        gap++;
        checkOutput($sformatf("idle_dout%0d", k), {s_ris, s_fal}, {IDLE, IDLE});
        checkOutput($sformatf("idle_underrun%0d", k), s_ur, 1'b0);
      end
      prev_oe = s_oe;
    end
  endtask

  initial begin
    fork
      monitorOutput(0);
      monitorOutput(1);
    join_none
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    int base_oe;
    int base_ur;
    int base_st;

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid_x[k]  = 1'b0;
      in_ris_x[k]    = '0;
      in_fal_x[k]    = '0;
      in_last_x[k]   = 1'b0;
      mon_en[k]      = 1'b0;
      oe_cycles[k]   = 0;
      ur_count[k]    = 0;
      lead_meas[k]   = -1;
      trail_meas[k]  = -1;
      last_gap[k]    = -1;
      stall_total[k] = 0;
    end

    // Reset state, both while held and after release
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rst_ready%0d", k), in_ready_x[k], 1'b0);
      checkOutput($sformatf("rst_oe%0d", k), oe_x[k], 1'b0);
      checkOutput($sformatf("rst_busy%0d", k), busy_x[k], 1'b0);
      checkOutput($sformatf("rst_dout%0d", k), dout_x[k], IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rel_ready%0d", k), in_ready_x[k], 1'b1);
      checkOutput($sformatf("rel_busy%0d", k), busy_x[k], 1'b0);
      checkOutput($sformatf("rel_oe%0d", k), oe_x[k], 1'b0);
      checkOutput($sformatf("rel_dout%0d", k), dout_x[k], IDLE);
      mon_en[k] = 1'b1;
    end
    idleCycles(2);

    // Three-beat burst, one lead and one trail cycle
    $display("[TB] three-beat burst");
    base_oe = oe_cycles[0];
    applyStimulus(0, 8'h01, 8'h02, 1'b0);
    applyStimulus(0, 8'h03, 8'h04, 1'b0);
    applyStimulus(0, 8'h05, 8'h06, 1'b1);
    waitIdle(0);
    checkOutput("burst3_oe_cycles", oe_cycles[0] - base_oe, 5);
    checkOutput("burst3_lead", lead_meas[0], 1);
    checkOutput("burst3_trail", trail_meas[0], 1);

    // One-beat burst followed at once by a six-beat burst. The second burst
    // fills the FIFO while the first one trails off.
    $display("[TB] fifo fill");
    base_oe = oe_cycles[0];
    base_st = stall_total[0];
    base_ur = ur_count[0];
    applyStimulus(0, 8'h11, 8'h12, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 8'(8'h21 + 2*i), 8'(8'h22 + 2*i), (i == 5));
    end
    waitIdle(0);
    checkOutput("full_stalls", stall_total[0] - base_st, 3);
    checkOutput("full_oe_cycles", oe_cycles[0] - base_oe, 11);
    checkOutput("full_gap", last_gap[0], 1);
    checkOutput("full_underruns", ur_count[0] - base_ur, 0);

    // Gap between beat 1 and beat 2 gives exactly one underrun cycle
    $display("[TB] underrun");
    base_oe = oe_cycles[0];
    base_ur = ur_count[0];
    applyStimulus(0, 8'h31, 8'h32, 1'b0);
    idleCycles(3);
    applyStimulus(0, 8'h33, 8'h34, 1'b1);
    waitIdle(0);
    checkOutput("ur_count", ur_count[0] - base_ur, 1);
    checkOutput("ur_oe_cycles", oe_cycles[0] - base_oe, 5);

    // Back-to-back bursts with no lead or trail
    $display("[TB] back-to-back, no lead/trail");
    base_oe = oe_cycles[1];
    base_ur = ur_count[1];
    applyStimulus(1, 8'h41, 8'h42, 1'b0);
    applyStimulus(1, 8'h43, 8'h44, 1'b1);
    applyStimulus(1, 8'h51, 8'h52, 1'b0);
    applyStimulus(1, 8'h53, 8'h54, 1'b1);
    waitIdle(1);
    checkOutput("b2b_oe_cycles", oe_cycles[1] - base_oe, 4);
    checkOutput("b2b_gap", last_gap[1], 1);
    checkOutput("b2b_lead", lead_meas[1], 0);
    checkOutput("b2b_trail", trail_meas[1], 0);
    checkOutput("b2b_underruns", ur_count[1] - base_ur, 0);

    // Reset in the middle of a burst: outputs go idle without a clock edge
    $display("[TB] reset mid-burst");
    applyStimulus(0, 8'h61, 8'h62, 1'b0);
    applyStimulus(0, 8'h63, 8'h64, 1'b0);
    applyStimulus(0, 8'h65, 8'h66, 1'b1);
    @(negedge clk);
    mon_en[0] = 1'b0;
    mon_en[1] = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("pre_reset_oe", oe_x[0], 1'b1);
    checkOutput("pre_reset_dout", dout_x[0], 8'h63);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_oe", oe_x[0], 1'b0);
    checkOutput("async_dout", dout_x[0], IDLE);
    checkOutput("async_ready", in_ready_x[0], 1'b0);
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_busy", busy_x[0], 1'b0);
    checkOutput("post_reset_ready", in_ready_x[0], 1'b1);
    checkOutput("post_reset_oe", oe_x[0], 1'b0);
    checkOutput("post_reset_dout", dout_x[0], IDLE);
    mon_en[0] = 1'b1;
    mon_en[1] = 1'b1;
    idleCycles(1);
    base_oe = oe_cycles[0];
    applyStimulus(0, 8'h71, 8'h72, 1'b1);
    waitIdle(0);
    checkOutput("post_reset_oe_cycles", oe_cycles[0] - base_oe, 3);

    checkOutput("sb_empty0", sbSize(0), 0);
    checkOutput("sb_empty1", sbSize(1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
